lfa_adc_reader: RTL
===================

LFA_ADC_READER -- requirements
Module: lfa_adc_reader

Interface
REQ-001 SHALL have parameter CH_LEFT, default 3'd3, ADC channel of the left LFA sensor.
REQ-002 SHALL have parameter CH_MIDDLE, default 3'd2, ADC channel of the middle LFA sensor.
REQ-003 SHALL have parameter CH_RIGHT, default 3'd1, ADC channel of the right LFA sensor.
REQ-004 SHALL have port clk_3125KHz, input, 1 bit: the only clock; all logic uses its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port adc_en, input, 1 bit: when high, the block runs continuous conversions.
REQ-007 SHALL have port adc_dout, input, 1 bit: serial data from the ADC128S022.
REQ-008 SHALL have port adc_cs_n, output, 1 bit: ADC chip select, active low.
REQ-009 SHALL have port adc_sclk, output, 1 bit: ADC serial clock.
REQ-010 SHALL have port adc_din, output, 1 bit: serial channel address sent to the ADC.
REQ-011 SHALL have ports left, middle, right, output, 12 bits each: latest sensor values, which feed the line-following stage.
REQ-012 SHALL have port sample_valid, output, 1 bit: one-clock pulse when left, middle and right all update.

Function
REQ-013 SHALL implement states IDLE, FRAME and GAP. IDLE->FRAME when adc_en=1. FRAME->GAP after 32 clocks. GAP->FRAME after 2 clocks if adc_en=1, else GAP->IDLE.
REQ-014 SHALL hold adc_cs_n=1 and adc_sclk=1 in IDLE and GAP; adc_cs_n SHALL be 0 for the whole of FRAME.
REQ-015 SHALL use 16 bit periods of 2 clocks each in FRAME. Phase 0 drives adc_sclk=0; phase 1 drives adc_sclk=1, giving 1.5625 MHz.
REQ-016 SHALL update adc_din at phase 0 only. Bit periods 2, 3 and 4 SHALL carry ADD2..ADD0 of the next channel in sequence; all other bit periods SHALL be 0.
REQ-017 SHALL sample adc_dout on the clock edge at which adc_sclk rises, during bit periods 4..15, shifting MSB first into a 12-bit register.
REQ-018 SHALL address channels in the fixed rotation CH_LEFT, CH_MIDDLE, CH_RIGHT, repeating. The data returned in a frame belongs to the address sent in the previous frame.
REQ-019 SHALL discard the data of the first frame after leaving IDLE, because it is the ADC's default channel 0.
REQ-020 SHALL stage left and middle results in shadow registers, then copy all three to the outputs on the clock after the frame carrying right data ends, asserting sample_valid for exactly that clock.
REQ-021 SHALL let an in-progress frame and gap complete when adc_en falls mid-frame. The frame's result SHALL still be processed, then the block SHALL enter IDLE. Outputs SHALL hold their last values.
REQ-022 SHALL restart the rotation at CH_LEFT, with a fresh discarded frame, on each IDLE->FRAME transition.
REQ-023 SHALL have a throughput of 34 clocks per frame and 102 clocks per full scan.

Reset
REQ-024 SHALL, while reset=1, drive state=IDLE, adc_cs_n=1, adc_sclk=1, adc_din=0, left=middle=right=0 and sample_valid=0, and clear the shift, shadow and rotation registers.
REQ-025 SHALL abort any frame in progress when reset asserts mid-frame (adc_cs_n=1 on the next clock), with no output update.
REQ-026 SHALL, when reset deasserts with adc_en=1, drop adc_cs_n on the first following clock (cycle 1). Frame n SHALL start at cycle 1+34(n-1).

Configuration
REQ-027 SHALL support macro LFA_AVG_EN. When defined, each output SHALL be (previous output + new sample)>>1 using a 13-bit sum with no overflow, and the first scan after reset SHALL use previous=0. When undefined, outputs SHALL be the raw samples.

Verification
REQ-028 SHALL cover this scan: reset, adc_en=1, ADC model returning ch3=0x0A0, ch2=0x9C4, ch1=0x0B4 -> sample_valid at cycle 135 with left=0x0A0, middle=0x9C4, right=0x0B4 (LFA_AVG_EN undefined).
REQ-029 SHALL cover the address check: decode adc_din over 4 frames -> addresses 3, 2, 1, 3. Also -> adc_sclk 16 rising edges per frame, and adc_cs_n high exactly 2 clocks between frames.
REQ-030 SHALL cover enable drop: adc_en=0 at cycle 50 -> frame 2 completes, adc_cs_n=1 from cycle 67 onward, no sample_valid, outputs stay 0.
REQ-031 SHALL cover reset mid-frame: reset at cycle 120 -> adc_cs_n=1 and all outputs 0 at cycle 121, no sample_valid.
REQ-032 SHALL cover averaging: LFA_AVG_EN defined, constant 0xFFF on all channels -> left=0x7FF after scan 1 and 0xBFF after scan 2.
REQ-033 SHALL cover edge values: 0x000 and 0xFFF on alternating channels -> exact values reproduced with no bit slip.

Source files
------------

// File: rtl/lfa_adc_reader.sv
// rtl/lfa_adc_reader.sv - ADC128S022 three-channel scanner feeding the line follower.
// Define LFA_AVG_EN to average each new sample with the previous output.
module lfa_adc_reader #(
  parameter logic [2:0] CH_LEFT   = 3'd3,
  parameter logic [2:0] CH_MIDDLE = 3'd2,
  parameter logic [2:0] CH_RIGHT  = 3'd1
) (
  input  logic        clk_3125KHz,
  input  logic        reset,
  input  logic        adc_en,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  output logic [11:0] left,
  output logic [11:0] middle,
  output logic [11:0] right,
  output logic        sample_valid
);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [11:0] shift;
  logic [11:0] shadow_left;
  logic [11:0] shadow_middle;
  logic [1:0]  addr_idx;
  logic [1:0]  data_idx;
  logic        first;

  logic [4:0]  next_cnt;
  logic [3:0]  bit_idx;
  logic [2:0]  cur_addr;
  logic        addr_bit;
  logic [11:0] new_left;
  logic [11:0] new_middle;
  logic [11:0] new_right;

  assign next_cnt = cnt + 5'd1;
  assign bit_idx  = next_cnt[4:1];

  always_comb begin
    cur_addr = CH_RIGHT;
    case (addr_idx)
      2'd0:    cur_addr = CH_LEFT;
      2'd1:    cur_addr = CH_MIDDLE;
      default: cur_addr = CH_RIGHT;
    endcase
  end

  // ADD2..ADD0 ride in bit periods 2..4, everything else is zero
  always_comb begin
    addr_bit = 1'b0;
    case (bit_idx)
      4'd2:    addr_bit = cur_addr[2];
      4'd3:    addr_bit = cur_addr[1];
      4'd4:    addr_bit = cur_addr[0];
      default: addr_bit = 1'b0;
    endcase
  end

`ifdef LFA_AVG_EN
  logic [12:0] sum_left;
  logic [12:0] sum_middle;
  logic [12:0] sum_right;
  assign sum_left   = {1'b0, left}   + {1'b0, shadow_left};
  assign sum_middle = {1'b0, middle} + {1'b0, shadow_middle};
  assign sum_right  = {1'b0, right}  + {1'b0, shift};
  assign new_left   = sum_left[12:1];
  assign new_middle = sum_middle[12:1];
  assign new_right  = sum_right[12:1];
`else
  assign new_left   = shadow_left;
  assign new_middle = shadow_middle;
  assign new_right  = shift;
`endif

  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 5'd0;
      shift         <= 12'd0;
      shadow_left   <= 12'd0;
      shadow_middle <= 12'd0;
      addr_idx      <= 2'd0;
      data_idx      <= 2'd0;
      first         <= 1'b1;
      adc_cs_n      <= 1'b1;
      adc_sclk      <= 1'b1;
      adc_din       <= 1'b0;
      left          <= 12'd0;
      middle        <= 12'd0;
      right         <= 12'd0;
      sample_valid  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (adc_en) begin
            state    <= FRAME;
            cnt      <= 5'd0;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            adc_din  <= 1'b0;
            addr_idx <= 2'd0;
            first    <= 1'b1;
          end
        end
        FRAME: begin
          if (cnt == 5'd31) begin
            state    <= GAP;
            cnt      <= 5'd0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
            addr_idx <= (addr_idx == 2'd2) ? 2'd0 : addr_idx + 2'd1;
            data_idx <= addr_idx;
            first    <= 1'b0;
            // this frame's data belongs to the address sent one frame earlier
            if (!first) begin
              case (data_idx)
                2'd0: shadow_left   <= shift;
                2'd1: shadow_middle <= shift;
                default: begin
                  left         <= new_left;
                  middle       <= new_middle;
                  right        <= new_right;
                  sample_valid <= 1'b1;
                end
              endcase
            end
          end else begin
            cnt      <= next_cnt;
            adc_sclk <= next_cnt[0];
            if (!next_cnt[0])
              adc_din <= addr_bit;
            else if (bit_idx >= 4'd4)
              shift <= {shift[10:0], adc_dout};
          end
        end
        GAP: begin
          if (cnt == 5'd0) begin
            cnt <= 5'd1;
          end else if (adc_en) begin
            state    <= FRAME;
            cnt      <= 5'd0;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            adc_din  <= 1'b0;
          end else begin
            state <= IDLE;
            cnt   <= 5'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
